alu_exec_unit: RTL

//  Multi-cycle execute stage directly downstream of the ALU control unit: consumes its 4-bit

---
 rtl/alu_exec_if.sv | 41 ++++
 rtl/alu_exec_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_if
//  Description : Handshake/data bundle between the ALU control stage, the
//                multi-cycle execute unit and the writeback/branch consumer.
//                  in_valid/in_ready  - operation handshake (issuer -> unit)
//                  alu_sel, op_a/op_b - operation code and operands
//                  out_valid/out_ready- result handshake (unit -> consumer)
//                  result, zf/cf/vf/sf- result and compare flags of op_a-op_b
//                  busy               - unit is not idle
//                Modports: master (issuer/consumer side), slave (execute unit).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             cf;
  logic             vf;
  logic             sf;
  logic             busy;

  modport master (
    output in_valid, alu_sel, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zf, cf, vf, sf, busy
  );

  modport slave (
    input  in_valid, alu_sel, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zf, cf, vf, sf, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Multi-cycle execute stage. Logic/arithmetic ops complete in
//                one cycle, shifts iterate one bit per cycle, optional MUL is
//                an iterative shift-add over WIDTH cycles. Compare flags of
//                op_a - op_b are captured when an operation is accepted.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - alu_exec_if.slave (valid/ready in, operands,
//                        valid/ready out, result, flags, busy)
//  Config      : define ALU_EXEC_MUL_EN to enable MUL on alu_sel 4'b0010;
//                otherwise that code is treated as unsupported (result 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  alu_exec_if.slave  bus
);

  localparam int c_shw = $clog2(WIDTH);
  // One extra bit so the counter can also hold WIDTH for the multiplier.
  localparam int c_cw  = c_shw + 1;

  localparam logic [3:0] c_add  = 4'b0000;
  localparam logic [3:0] c_sub  = 4'b0001;
  localparam logic [3:0] c_pass = 4'b0011;
  localparam logic [3:0] c_or   = 4'b0100;
  localparam logic [3:0] c_and  = 4'b0101;
  localparam logic [3:0] c_xor  = 4'b0111;
  localparam logic [3:0] c_srl  = 4'b1000;
  localparam logic [3:0] c_sll  = 4'b1001;
  localparam logic [3:0] c_sra  = 4'b1010;
  localparam logic [3:0] c_slt  = 4'b1101;
  localparam logic [3:0] c_sltu = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef ALU_EXEC_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  r_work;
  logic [c_cw-1:0]   r_cnt;
  logic [3:0]        r_sel;
  logic              r_zf, r_cf, r_vf, r_sf;
  logic              r_out_valid;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [c_cw-1:0] c_mul_cnt = c_cw'(WIDTH);
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [WIDTH-1:0]  w_mul_next;
`endif

  logic [WIDTH:0]    w_diff_full;
  logic [WIDTH-1:0]  w_diff;
  logic              w_zf, w_cf, w_vf, w_sf;
  logic [c_shw-1:0]  w_shamt;
  logic              w_accept;
  logic              w_is_shift;
  logic [WIDTH-1:0]  w_quick;
  logic [WIDTH-1:0]  w_shift_next;

  // Flags come from D = op_a + ~op_b + 1; bit WIDTH is the carry-out.
  assign w_diff_full = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_diff      = w_diff_full[WIDTH-1:0];
  assign w_cf        = w_diff_full[WIDTH];
  assign w_zf        = (w_diff == '0);
  assign w_sf        = w_diff[WIDTH-1];
  assign w_vf        = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != bus.op_a[WIDTH-1]);
  assign w_shamt     = bus.op_b[c_shw-1:0];
  assign w_accept    = bus.in_valid && (r_state == S_IDLE);
  assign w_is_shift  = (bus.alu_sel == c_srl) || (bus.alu_sel == c_sll) ||
                       (bus.alu_sel == c_sra);

  // Result of every op that finishes in the accept cycle. A shift only lands
  // here with a zero shift amount, so it passes op_a through unchanged.
  always_comb begin
    w_quick = '0;
    case (bus.alu_sel)
      c_add:                  w_quick = bus.op_a + bus.op_b;
      c_sub:                  w_quick = w_diff;
      c_pass:                 w_quick = bus.op_b;
      c_or:                   w_quick = bus.op_a | bus.op_b;
      c_and:                  w_quick = bus.op_a & bus.op_b;
      c_xor:                  w_quick = bus.op_a ^ bus.op_b;
      c_srl, c_sll, c_sra:    w_quick = bus.op_a;
      c_slt:                  w_quick = {{(WIDTH-1){1'b0}}, w_sf ^ w_vf};
      c_sltu:                 w_quick = {{(WIDTH-1){1'b0}}, ~w_cf};
      default:                w_quick = '0;
    endcase
  end

  always_comb begin
    w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
    case (r_sel)
      c_srl:   w_shift_next = {1'b0, r_work[WIDTH-1:1]};
      c_sll:   w_shift_next = {r_work[WIDTH-2:0], 1'b0};
      default: w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_zf        <= 1'b0;
      r_cf        <= 1'b0;
      r_vf        <= 1'b0;
      r_sf        <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_zf   <= w_zf;
            r_cf   <= w_cf;
            r_vf   <= w_vf;
            r_sf   <= w_sf;
            r_sel  <= bus.alu_sel;
            r_work <= bus.op_a;
            r_cnt  <= {1'b0, w_shamt};
            if (w_is_shift && (w_shamt != '0)) begin
              r_state <= S_SHIFT;
            end
`ifdef ALU_EXEC_MUL_EN
            else if (bus.alu_sel == 4'b0010) begin
              r_state  <= S_MUL;
              r_cnt    <= c_mul_cnt;
              r_acc    <= '0;
              r_mcand  <= bus.op_a;
              r_mplier <= bus.op_b;
            end
`endif
            else begin
              r_result    <= w_quick;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_shift_next;
          r_cnt  <= r_cnt - c_cw'(1);
          if (r_cnt == c_cw'(1)) begin
            r_result    <= w_shift_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`ifdef ALU_EXEC_MUL_EN
        S_MUL: begin
          r_acc    <= w_mul_next;
          r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt - c_cw'(1);
          if (r_cnt == c_cw'(1)) begin
            r_result    <= w_mul_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so no operation appears accepted during reset.
  assign bus.in_ready  = rst_n && (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zf        = r_zf;
  assign bus.cf        = r_cf;
  assign bus.vf        = r_vf;
  assign bus.sf        = r_sf;

endmodule
`default_nettype wire
